// File: rtl/mac_acc_block.sv
// mac_acc_block: frames consecutive product beats into a wide saturating
// accumulator and returns one registered result per frame over valid/ready.
module mac_acc_block #(
    parameter int unsigned MAC_CONF_WIDTH = 3,
    parameter int unsigned MAC_MIN_WIDTH  = 8,
    parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int unsigned MAC_ACC_WIDTH  = 48,    // must be >= MAC_INT_WIDTH
    parameter int unsigned MAC_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_INT_WIDTH-1:0]  in_data,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_ACC_WIDTH-1:0]  out_data,
    output logic [MAC_CNT_WIDTH-1:0]  out_cnt,
    output logic                      out_ovf,
    output logic [MAC_CONF_WIDTH-1:0] out_cfg
);

    localparam int unsigned SUM_W = MAC_ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                    state;
    logic [MAC_ACC_WIDTH-1:0]  acc;
    logic [MAC_CNT_WIDTH-1:0]  cnt;
    logic                      ovf;
    logic [MAC_CONF_WIDTH-1:0] cfg_q;

    logic                      accept;
    logic                      start;
    logic [SUM_W-1:0]          sum;
    logic [MAC_ACC_WIDTH-1:0]  acc_nxt;
    logic [MAC_CNT_WIDTH-1:0]  cnt_nxt;
    logic                      ovf_nxt;
    logic [MAC_CONF_WIDTH-1:0] cfg_nxt;

    // In HOLD a new beat can only enter while the held result drains.
    assign in_ready = (state != S_HOLD) || (out_valid && out_ready);
    assign accept   = in_valid && in_ready;

    // Next accumulator contents for an accepted beat; any beat outside ACC opens a frame.
    always_comb begin
        start   = (state != S_ACC) || in_first;
        sum     = SUM_W'(acc) + SUM_W'(in_data);
        acc_nxt = MAC_ACC_WIDTH'(in_data);
        cnt_nxt = MAC_CNT_WIDTH'(1);
        ovf_nxt = 1'b0;
        cfg_nxt = cfg;
        if (!start) begin
            acc_nxt = sum[MAC_ACC_WIDTH] ? {MAC_ACC_WIDTH{1'b1}} : sum[MAC_ACC_WIDTH-1:0];
            ovf_nxt = ovf || sum[MAC_ACC_WIDTH];
            cnt_nxt = (&cnt) ? cnt : cnt + MAC_CNT_WIDTH'(1);
            cfg_nxt = cfg_q;
        end
    end

    // Frame state machine, accumulator and output result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            cfg_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_cfg   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                ovf   <= ovf_nxt;
                cfg_q <= cfg_nxt;
                if (in_last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_nxt;
                    out_cnt   <= cnt_nxt;
                    out_ovf   <= ovf_nxt;
                    out_cfg   <= cfg_nxt;
                    state     <= S_HOLD;
                end else begin
                    state     <= S_ACC;
                end
            end else if (state == S_HOLD && out_ready) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_block.sv
// tb_mac_acc_block: table of framed beats plus hand-written corner sequences,
// results checked through an expected-result queue.
module tb_mac_acc_block;

    localparam int unsigned CW = 3;
    localparam int unsigned IW = 40;
    localparam int unsigned AW = 40;
    localparam int unsigned NW = 16;

    localparam logic [CW-1:0] C_SINGLE = 3'd0;
    localparam logic [CW-1:0] C_DUAL   = 3'd1;
    localparam logic [CW-1:0] C_QUAD   = 3'd2;
    localparam logic [AW-1:0] MAXV     = 40'hFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [CW-1:0] cfg = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic [NW-1:0] out_cnt;
    logic          out_ovf;
    logic [CW-1:0] out_cfg;

    mac_acc_block #(
        .MAC_CONF_WIDTH(CW),
        .MAC_MIN_WIDTH (8),
        .MAC_INT_WIDTH (IW),
        .MAC_ACC_WIDTH (AW),
        .MAC_CNT_WIDTH (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .in_last  (in_last),
        .cfg      (cfg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf),
        .out_cfg  (out_cfg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] d;
        logic [NW-1:0] c;
        logic          o;
        logic [CW-1:0] g;
    } exp_t;

    typedef struct {
        logic [IW-1:0] d;
        logic          f;
        logic          l;
        logic [CW-1:0] c;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   waits = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [IW-1:0] d, input logic f, input logic l, input logic [CW-1:0] c,
                       input logic [AW-1:0] ed, input int ec, input logic eo, input logic [CW-1:0] eg);
        vec_t v;
        v.d = d; v.f = f; v.l = l; v.c = c;
        v.e.d = ed; v.e.c = NW'(ec); v.e.o = eo; v.e.g = eg;
        tbl.push_back(v);
    endtask

    // Drive one beat from posedge+1; returns at posedge+1 after it is accepted.
    task automatic beat(input logic [IW-1:0] d, input logic f, input logic l, input logic [CW-1:0] c,
                        input logic push, input exp_t e);
        int w;
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l; cfg = c;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            w++;
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL beat_accept: in_ready stuck at 0 for data %0h", d);
        end else if (push && l) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = IW'({$urandom(), $urandom()});
        cfg      = CW'($urandom());
    endtask

    function automatic exp_t mk(input logic [AW-1:0] d, input int c, input logic o, input logic [CW-1:0] g);
        exp_t e;
        e.d = d; e.c = NW'(c); e.o = o; e.g = g;
        return e;
    endfunction

    // Scoreboard: every completed output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_extra: unexpected result data=%0h cnt=%0d", out_data, out_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", 64'(out_data), 64'(e.d));
                check("sb_cnt",  64'(out_cnt),  64'(e.c));
                check("sb_ovf",  64'(out_ovf),  64'(e.o));
                check("sb_cfg",  64'(out_cfg),  64'(e.g));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t none;
        none = mk('0, 0, 1'b0, '0);

        // Vectors: on a last beat, the record carries the expected frame result.
        add(40'd100, 1, 0, C_SINGLE, '0, 0, 0, '0);
        add(40'd200, 0, 0, C_QUAD,   '0, 0, 0, '0);
        add(40'd300, 0, 1, C_QUAD,   40'd600, 3, 0, C_SINGLE);
        add(MAXV,    1, 0, C_DUAL,   '0, 0, 0, '0);
        add(40'd5,   0, 0, C_SINGLE, '0, 0, 0, '0);
        add(40'd3,   0, 1, C_SINGLE, MAXV, 3, 1, C_DUAL);
        add(40'd1,   1, 1, C_QUAD,   40'd1, 1, 0, C_QUAD);
        add(40'd50,  1, 0, C_SINGLE, '0, 0, 0, '0);
        add(40'd60,  0, 0, C_SINGLE, '0, 0, 0, '0);
        add(40'd70,  1, 0, C_DUAL,   '0, 0, 0, '0);
        add(40'd80,  0, 1, C_QUAD,   40'd150, 2, 0, C_DUAL);
        add(40'd5,   1, 1, 3'd7,     40'd5, 1, 0, 3'd7);
        add(40'd0,   1, 1, C_SINGLE, 40'd0, 1, 0, C_SINGLE);
        add(40'd11,  0, 1, C_QUAD,   40'd11, 1, 0, C_QUAD);
        add(MAXV - 40'd1, 1, 0, C_DUAL, '0, 0, 0, '0);
        add(40'd1,   0, 1, C_SINGLE, MAXV, 2, 0, C_DUAL);

        // Reset values.
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_cnt",   64'(out_cnt),   64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_out_cfg",   64'(out_cfg),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table, streamed back-to-back with out_ready held high.
        waits = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].d, tbl[i].f, tbl[i].l, tbl[i].c, 1'b1, tbl[i].e);
        end
        check("stream_no_stall", 64'(waits), 64'd0);
        @(negedge clk);
        check("pulse_hi", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("pulse_lo", 64'(out_valid), 64'd0);

        // Output stall, then drain together with a new one-beat frame.
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(40'd7, 1, 1, C_SINGLE, 1'b1, mk(40'd7, 1, 0, C_SINGLE));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data",  64'(out_data),  64'd7);
            check("stall_ready", 64'(in_ready),  64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        beat(40'd9, 1, 1, C_QUAD, 1'b1, mk(40'd9, 1, 0, C_QUAD));
        @(negedge clk);
        check("drain_data", 64'(out_data), 64'd9);

        // Gaps between beats, with junk on the idle input lines.
        @(posedge clk); #1;
        beat(40'd10, 1, 0, C_DUAL, 1'b1, none);
        in_last = 1'b1;
        in_first = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        beat(40'd20, 0, 1, C_SINGLE, 1'b1, mk(40'd30, 2, 0, C_DUAL));
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        beat(40'd100, 1, 0, C_SINGLE, 1'b0, none);
        beat(40'd200, 0, 0, C_SINGLE, 1'b0, none);
        beat(40'd300, 0, 1, C_SINGLE, 1'b0, none);
        #2;
        check("hold_data", 64'(out_data), 64'd600);
        rst = 1'b0;
        #1;
        check("arst_valid",    64'(out_valid), 64'd0);
        check("arst_data",     64'(out_data),  64'd0);
        check("arst_in_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        beat(40'd4, 1, 1, C_DUAL, 1'b1, mk(40'd4, 1, 0, C_DUAL));
        @(negedge clk);
        check("post_rst_data", 64'(out_data), 64'd4);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_acc_block.md
# mac_acc_block

Accumulation stage directly downstream of the MAC multiply block. It takes the combined product word of each cycle (single, dual or quad configuration), sums consecutive products into a wide saturating accumulator, and frames results with first/last markers. It returns one registered result per frame over a valid/ready output handshake. Upstream back-pressure is exposed through `in_ready`, so the multiply stage and operand feeders can stall.

## Interface
- `MAC_CONF_WIDTH`, 3, configuration width; `cfg[1:0]` is coded with `MAC_SINGLE` / `MAC_DUAL` / `MAC_QUAD` from mac_const.vh.
- `MAC_MIN_WIDTH`, 8, base operand width.
- `MAC_INT_WIDTH`, 5*MAC_MIN_WIDTH, width of the incoming product word.
- `MAC_ACC_WIDTH`, 48, accumulator width; must be ≥ MAC_INT_WIDTH.
- `MAC_CNT_WIDTH`, 16, beat-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a product beat is presented.
- `in_ready`  out  1  the block accepts the beat this cycle.
- `in_data`  in  MAC_INT_WIDTH  unsigned product from the multiply stage.
- `in_first`  in  1  beat starts a new frame: load, do not add.
- `in_last`  in  1  beat ends the frame and produces a result.
- `cfg`  in  MAC_CONF_WIDTH  configuration; sampled on the frame's first accepted beat.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  MAC_ACC_WIDTH  accumulated sum.
- `out_cnt`  out  MAC_CNT_WIDTH  beats in the frame, saturating.
- `out_ovf`  out  1  the accumulator saturated during the frame.
- `out_cfg`  out  MAC_CONF_WIDTH  cfg latched for the frame.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- State machine states:
  - IDLE: no frame open.
  - ACC: frame open.
  - HOLD: result waiting on `out_ready`.
- `in_ready` = 1 in IDLE and ACC; in HOLD it equals `out_valid && out_ready` (pass-through on drain).
- Accepted beat in IDLE, or in any state with `in_first=1`:
  - acc ← zero-extended `in_data`; cnt ← 1; ovf ← 0; cfg latched.
  - `in_first` is implied in IDLE.
- Accepted beat in ACC without `in_first`:
  - acc ← acc + `in_data`, computed at MAC_ACC_WIDTH+1 bits.
  - On carry-out, acc ← all-ones and ovf ← 1 (sticky to frame end).
  - cnt ← cnt+1, saturating at all-ones.
  - `cfg` is ignored on this beat.
- `in_first` in ACC silently discards the partial frame.
- Accepted beat with `in_last`:
  - The updated acc, cnt, ovf and cfg load the output registers.
  - `out_valid` ← 1; state → HOLD.
- Accepted beat without `in_last`: state → ACC.
- `in_first && in_last` on the same beat is a one-beat frame: out_data = in_data, out_cnt = 1.
- In HOLD:
  - `out_ready=1` clears `out_valid`.
  - If an input beat is accepted in the same cycle, it is processed as an IDLE beat: next state is ACC, or HOLD again if it also has `in_last`.
  - Otherwise state → IDLE.
- `cfg` values outside the three codes are accepted and passed through on `out_cfg`; the sum is unaffected, because arithmetic is independent of configuration.
- `in_valid=0` beats are never counted. `in_data` is ignored when not accepted.

## Timing
- Reset (asynchronous assert, synchronous-release use):
  - state = IDLE; acc, cnt, ovf all 0.
  - `out_valid`=0, `out_data`=0, `out_cnt`=0, `out_ovf`=0, `out_cfg`=0.
  - `in_ready`=1.
- Reset mid-frame or in HOLD drops all data immediately, without waiting for a clock edge.
- Latency: a last beat accepted on edge t makes `out_valid` high after edge t; the result is visible in cycle t+1.
- Throughput: one beat per cycle, including back-to-back one-beat frames while `out_ready` is held at 1.
- Output registers are stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready` in HOLD only. There is no other input-to-output combinational path.

## Test plan
- Basic frame: frame 100 (first), 200, 300 (last), `out_ready`=1 → one cycle after the last beat, out_data=600, out_cnt=3, out_ovf=0; `out_valid` pulses for one cycle.
- Stall on output:
  - Frame 7 (first+last) with `out_ready`=0 for 4 cycles → `out_valid` and out_data=7 held, `in_ready`=0 throughout.
  - Raise `out_ready` together with a new `in_valid` beat 9 (first+last) → the next cycle shows out_data=9.
- Saturation: with MAC_ACC_WIDTH=40, frame 2^40−1 (first), 5, 3 (last) → out_data=2^40−1, out_ovf=1, out_cnt=3. The next frame 1 (first+last) → out_ovf=0.
- Restart mid-frame: 50 (first), 60, then 70 (first), 80 (last) → out_data=150, out_cnt=2. `cfg` driven to DUAL on the 70 beat → out_cfg=DUAL.
- Reset mid-operation: assert `rst` low asynchronously between edges while in HOLD with out_data=600 → `out_valid` and out_data go to 0 before the next edge. After release, frame 4 (first+last) → out_data=4.
- Gaps: a frame with `in_valid` low for 3 cycles between beats 10 and 20 → out_data=30, out_cnt=2.
